// File: rtl/array_5_ctrl.sv
// Access controller for a 2048x12 1R1W table: zeroing sweep, round-robin A/B write arbitration, and a single read port (ARRAY5_CTRL_RW_BYPASS_EN selects collision handling).
// Latency: a read response arrives 1 cycle after acceptance.
// Backpressure: all readies are low during the sweep and in a flush cycle; collisions are bypassed or stall the read.
module array_5_ctrl #(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 12,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush_i,
  output logic              init_done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wa_valid,
  output logic              wa_ready,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic                init_done_q, init_done_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_hold_q, rsp_hold_d;

  logic                accept_ok;
  logic                gnt_a, gnt_b, w_gnt;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                same_addr;
  logic                rd_fire;
  logic [DATA_W-1:0]   rsp_now;

`ifdef ARRAY5_CTRL_RW_BYPASS_EN
  logic                byp_vld_q, byp_vld_d;
  logic [DATA_W-1:0]   byp_data_q, byp_data_d;
`endif

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    init_done_d = init_done_q;
    rr_ptr_d    = rr_ptr_q;
    sram_w_en   = 1'b0;
    sram_w_addr = '0;
    sram_w_data = '0;

    // rr_ptr_q names the preferred requester when both are valid: 0 = A, 1 = B.
    accept_ok = (state_q == ST_RUN) & ~flush_i;
    gnt_a     = accept_ok & wa_valid & (~wb_valid | ~rr_ptr_q);
    gnt_b     = accept_ok & wb_valid & (~wa_valid |  rr_ptr_q);
    w_gnt     = gnt_a | gnt_b;
    win_addr  = gnt_b ? wb_addr : wa_addr;
    win_data  = gnt_b ? wb_data : wa_data;
    same_addr = w_gnt & (rd_addr == win_addr);

`ifdef ARRAY5_CTRL_RW_BYPASS_EN
    rd_ready = init_done_q & ~flush_i;
`else
    rd_ready = init_done_q & ~flush_i & ~(rd_valid & same_addr);
`endif
    rd_fire     = rd_valid & rd_ready;
    sram_r_en   = rd_fire;
    sram_r_addr = rd_addr;
    wa_ready    = gnt_a;
    wb_ready    = gnt_b;

    if (gnt_a) rr_ptr_d = 1'b1;
    if (gnt_b) rr_ptr_d = 1'b0;

    case (state_q)
      ST_SWEEP: begin
        sram_w_en   = 1'b1;
        sram_w_addr = sweep_cnt_q;
        sram_w_data = INIT_VAL;
        if (flush_i) begin
          sweep_cnt_d = '0;
        end else if (sweep_cnt_q == LAST_ADDR) begin
          sweep_cnt_d = '0;
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      default: begin
        sram_w_en   = w_gnt;
        sram_w_addr = win_addr;
        sram_w_data = win_data;
        if (flush_i) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = '0;
          init_done_d = 1'b0;
        end
      end
    endcase

    // A flush does not cancel a response already owed for last cycle's read.
    rsp_valid_d = rd_fire;
`ifdef ARRAY5_CTRL_RW_BYPASS_EN
    byp_vld_d  = rd_fire & same_addr;
    byp_data_d = (rd_fire & same_addr) ? win_data : byp_data_q;
    rsp_now    = byp_vld_q ? byp_data_q : sram_r_data;
`else
    rsp_now    = sram_r_data;
`endif
    rsp_hold_d = rsp_valid_q ? rsp_now : rsp_hold_q;
    rsp_data   = rsp_valid_q ? rsp_now : rsp_hold_q;
    rsp_valid  = rsp_valid_q;
    init_done  = init_done_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= '0;
      init_done_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_hold_d;
    end
  end

`ifdef ARRAY5_CTRL_RW_BYPASS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_vld_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_vld_q  <= byp_vld_d;
      byp_data_q <= byp_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_array_5_ctrl.sv
// Directed bench for array_5_ctrl with a behavioural 1R1W macro and a response scoreboard.
module tb_array_5_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        init_done;
  logic        rd_valid, rd_ready;
  logic [10:0] rd_addr;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic        wa_valid, wa_ready, wb_valid, wb_ready;
  logic [10:0] wa_addr, wb_addr;
  logic [11:0] wa_data, wb_data;
  logic        sram_r_en, sram_w_en;
  logic [10:0] sram_r_addr, sram_w_addr;
  logic [11:0] sram_r_data, sram_w_data;

  logic [11:0] mem [2048];
  logic [11:0] exp_mem [2048];
  logic [11:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  array_5_ctrl dut (
    .clock(clock), .reset_n(reset_n), .flush_i(flush_i), .init_done(init_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
  );

  // Macro model: registered read returns the pre-write contents on a same-address collision.
  always @(posedge clock) begin
    if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", {20'd0, rsp_data}, {20'd0, e});
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sweep_walk(input string tag);
    int bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (sram_w_en !== 1'b1 || sram_w_addr !== i[10:0] || sram_w_data !== 12'h000 ||
          init_done !== 1'b0 || rd_ready !== 1'b0 || wa_ready !== 1'b0 || wb_ready !== 1'b0)
        bad++;
      cyc();
    end
    chk({tag, "_walk"}, bad, 0);
    chk({tag, "_init_done"}, init_done, 1);
    for (int i = 0; i < 2048; i++) exp_mem[i] = 12'h000;
  endtask

  task automatic do_write_a(input logic [10:0] a, input logic [11:0] d);
    wa_valid = 1'b1; wa_addr = a; wa_data = d;
    settle();
    chk("wr_a_ready", wa_ready, 1);
    exp_mem[a] = d;
    cyc();
    wa_valid = 1'b0;
  endtask

  task automatic do_read(input logic [10:0] a);
    rd_valid = 1'b1; rd_addr = a;
    settle();
    chk("rd_ready", rd_ready, 1);
    exp_q.push_back(exp_mem[a]);
    cyc();
    rd_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int v;
    for (int i = 0; i < 2048; i++) mem[i] = 12'hA5A ^ i[11:0];
    reset_n = 1'b0; flush_i = 1'b0;
    rd_valid = 1'b0; rd_addr = '0;
    wa_valid = 1'b0; wa_addr = '0; wa_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) cyc();
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_sweep_addr", sram_w_addr, 0);

    // 1: sweep after reset release, then every entry reads zero
    @(negedge clock); reset_n = 1'b1; #1;
    sweep_walk("sweep1");
    bad = 0;
    for (int a = 0; a < 2048; a++) begin
      rd_valid = 1'b1; rd_addr = a[10:0];
      settle();
      if (rd_ready !== 1'b1) bad++;
      exp_q.push_back(exp_mem[a]);
      cyc();
    end
    rd_valid = 1'b0;
    chk("read_all_ready", bad, 0);
    cyc();

    // 2: round-robin with both requesters valid, then B alone after B won
    wa_valid = 1'b1; wb_valid = 1'b1; wa_addr = 11'd5; wb_addr = 11'd6;
    for (int k = 0; k < 4; k++) begin
      wa_data = 12'h100 + k[11:0]; wb_data = 12'h200 + k[11:0];
      settle();
      chk($sformatf("arb_a_%0d", k), wa_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("arb_b_%0d", k), wb_ready, (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) exp_mem[5] = wa_data; else exp_mem[6] = wb_data;
      cyc();
    end
    wa_valid = 1'b0; wb_data = 12'h2EE;
    settle();
    chk("arb_b_alone", wb_ready, 1);
    chk("arb_a_idle", wa_ready, 0);
    exp_mem[6] = 12'h2EE;
    cyc();
    wb_valid = 1'b0;
    do_read(11'd5);
    do_read(11'd6);
    cyc();

    // 3: write then read the top address; back-to-back reads
    do_write_a(11'h7FF, 12'hABC);
    do_read(11'h7FF);
    chk("top_rsp_valid", rsp_valid, 1);
    chk("top_rsp_data", rsp_data, 12'hABC);
    cyc();
    chk("top_rsp_pulse", rsp_valid, 0);
    chk("top_rsp_hold", rsp_data, 12'hABC);
    do_write_a(11'd0, 12'h311);
    do_write_a(11'd1, 12'h322);
    do_write_a(11'd2, 12'h333);
    v = 0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_addr = i[10:0];
      settle();
      exp_q.push_back(exp_mem[i]);
      cyc();
      if (rsp_valid === 1'b1) v++;
    end
    rd_valid = 1'b0;
    chk("b2b_rsp_count", v, 3);
    cyc();
    chk("b2b_rsp_end", rsp_valid, 0);

    // 4: same-cycle write and read to 0x010
    do_write_a(11'h010, 12'h055);
    wa_valid = 1'b1; wa_addr = 11'h010; wa_data = 12'h123;
    rd_valid = 1'b1; rd_addr = 11'h010;
    settle();
    chk("col_wa_ready", wa_ready, 1);
    exp_mem[16] = 12'h123;
`ifdef ARRAY5_CTRL_RW_BYPASS_EN
    chk("col_rd_ready", rd_ready, 1);
    exp_q.push_back(12'h123);
    cyc();
    wa_valid = 1'b0; rd_valid = 1'b0;
    chk("col_rsp_valid", rsp_valid, 1);
`else
    chk("col_rd_ready", rd_ready, 0);
    cyc();
    wa_valid = 1'b0;
    settle();
    chk("col_rd_retry", rd_ready, 1);
    exp_q.push_back(12'h123);
    cyc();
    rd_valid = 1'b0;
    chk("col_rsp_valid", rsp_valid, 1);
`endif
    cyc();
    do_read(11'h010);
    // Read and write to different addresses proceed together
    wa_valid = 1'b1; wa_addr = 11'h001; wa_data = 12'h4C4;
    rd_valid = 1'b1; rd_addr = 11'h7FF;
    settle();
    chk("par_wa_ready", wa_ready, 1);
    chk("par_rd_ready", rd_ready, 1);
    exp_q.push_back(exp_mem[11'h7FF]);
    exp_mem[1] = 12'h4C4;
    cyc();
    wa_valid = 1'b0; rd_valid = 1'b0;
    do_read(11'h001);
    cyc();

    // 5: flush in RUN with a response in flight, then flush mid-sweep
    rd_valid = 1'b1; rd_addr = 11'h7FF;
    settle();
    chk("pre_flush_rd_ready", rd_ready, 1);
    exp_q.push_back(exp_mem[11'h7FF]);
    cyc();
    flush_i = 1'b1; wa_valid = 1'b1; wa_addr = 11'd3; wa_data = 12'hFFF;
    settle();
    chk("flush_rd_ready", rd_ready, 0);
    chk("flush_wa_ready", wa_ready, 0);
    chk("flush_r_en", sram_r_en, 0);
    chk("flush_rsp_kept", rsp_valid, 1);
    chk("flush_init_done", init_done, 1);
    cyc();
    flush_i = 1'b0; rd_valid = 1'b0; wa_valid = 1'b0;
    settle();
    chk("after_flush_init_done", init_done, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sram_w_addr !== i[10:0] || init_done !== 1'b0) bad++;
      cyc();
    end
    chk("flush_sweep_to_1000", bad, 0);
    chk("flush_cnt_1000", sram_w_addr, 1000);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    sweep_walk("sweep_refl");
    do_read(11'h7FF);
    do_read(11'h010);
    cyc();

    // 6: reset while a response is in flight
    rd_valid = 1'b1; rd_addr = 11'd5;
    settle();
    chk("pre_rst_rd_ready", rd_ready, 1);
    @(posedge clock); #2;
    reset_n = 1'b0; rd_valid = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_init_done", init_done, 0);
    repeat (2) cyc();
    @(negedge clock); reset_n = 1'b1; #1;
    sweep_walk("sweep_rst");
    repeat (3) cyc();
    chk("rsp_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
